// File: rtl/branch_predictor_gshare_if.sv
// Fetch-query, commit-update and statistics signals between IF/ROB and the branch predictor.
// The master side (IF/ROB) drives queries and updates; the predictor is the slave.
interface branch_predictor_gshare_if #(
    parameter int GHR_BITS  = 8,
    parameter int STAT_BITS = 32
);
    logic                 rdy;
    logic                 q_valid;
    logic [31:0]          q_pc;
    logic [31:0]          q_inst;
    logic                 pred_taken;
    logic [31:0]          pred_imm;
    logic [GHR_BITS-1:0]  pred_ghr;
    logic                 upd_valid;
    logic [31:0]          upd_pc;
    logic [GHR_BITS-1:0]  upd_ghr;
    logic                 upd_taken;
    logic                 upd_mispredict;
    logic [STAT_BITS-1:0] stat_branches;
    logic [STAT_BITS-1:0] stat_mispredicts;

    modport master (
        output rdy, q_valid, q_pc, q_inst,
        output upd_valid, upd_pc, upd_ghr, upd_taken, upd_mispredict,
        input  pred_taken, pred_imm, pred_ghr, stat_branches, stat_mispredicts
    );

    modport slave (
        input  rdy, q_valid, q_pc, q_inst,
        input  upd_valid, upd_pc, upd_ghr, upd_taken, upd_mispredict,
        output pred_taken, pred_imm, pred_ghr, stat_branches, stat_mispredicts
    );
endinterface

// File: rtl/branch_predictor_gshare.sv
// Gshare/bimodal branch predictor: same-cycle prediction and immediate for IF,
// speculative global history with commit-time recovery, saturating-counter PHT and statistics.
module branch_predictor_gshare #(
    parameter int PHT_ENTRIES = 256,
    parameter int CNT_BITS    = 2,
    parameter int CNT_INIT    = 1,
    parameter int GHR_BITS    = 8,
    parameter int USE_GSHARE  = 1,
    parameter int STAT_BITS   = 32
) (
    input logic                     clk,
    input logic                     rst,
    branch_predictor_gshare_if.slave bp
);
    localparam int IDX_BITS = $clog2(PHT_ENTRIES);
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
    localparam logic [CNT_BITS-1:0] CNT_RST = CNT_BITS'(CNT_INIT);

    logic [CNT_BITS-1:0]  pht_q [PHT_ENTRIES];
    logic [GHR_BITS-1:0]  ghr_q, ghr_d;
    logic [STAT_BITS-1:0] br_q, br_d;
    logic [STAT_BITS-1:0] mp_q, mp_d;

    logic [IDX_BITS-1:0]  q_idx, u_idx;
    logic [CNT_BITS-1:0]  q_cnt, u_cnt, u_cnt_d;
    logic                 is_jal, is_br, pred_taken;
    logic [31:0]          imm_j, imm_b;
    logic                 unused_bits;

    function automatic logic [IDX_BITS-1:0] pht_index(input logic [31:0] pc,
                                                      input logic [GHR_BITS-1:0] ghr);
        logic [IDX_BITS-1:0] base;
        base = pc[IDX_BITS+1:2];
        if (USE_GSHARE != 0) return base ^ IDX_BITS'(ghr);
        return base;
    endfunction

    always_comb begin
        is_jal     = (bp.q_inst[6:0] == OP_JAL);
        is_br      = (bp.q_inst[6:0] == OP_BRANCH);
        q_idx      = pht_index(bp.q_pc, ghr_q);
        u_idx      = pht_index(bp.upd_pc, bp.upd_ghr);
        q_cnt      = pht_q[q_idx];
        u_cnt      = pht_q[u_idx];
        pred_taken = bp.q_valid && (is_jal || (is_br && q_cnt[CNT_BITS-1]));
        imm_j      = {{12{bp.q_inst[31]}}, bp.q_inst[19:12], bp.q_inst[20],
                      bp.q_inst[30:21], 1'b0};
        imm_b      = {{20{bp.q_inst[31]}}, bp.q_inst[7], bp.q_inst[30:25],
                      bp.q_inst[11:8], 1'b0};
    end

    assign bp.pred_taken       = pred_taken;
    assign bp.pred_imm         = is_jal ? imm_j : imm_b;
    assign bp.pred_ghr         = ghr_q;
    assign bp.stat_branches    = br_q;
    assign bp.stat_mispredicts = mp_q;

    always_comb begin
        if (bp.upd_taken) u_cnt_d = (u_cnt == CNT_MAX) ? u_cnt : u_cnt + 1'b1;
        else              u_cnt_d = (u_cnt == '0)      ? u_cnt : u_cnt - 1'b1;
    end

    // A mispredict flushes the fetch path, so recovery wins over the speculative shift.
    always_comb begin
        ghr_d = ghr_q;
        br_d  = br_q;
        mp_d  = mp_q;
        if (bp.rdy) begin
            if (bp.upd_valid && bp.upd_mispredict)
                ghr_d = (bp.upd_ghr << 1) | GHR_BITS'(bp.upd_taken);
            else if (bp.q_valid && is_br)
                ghr_d = (ghr_q << 1) | GHR_BITS'(pred_taken);
            if (bp.upd_valid) begin
                if (br_q != '1) br_d = br_q + 1'b1;
                if (bp.upd_mispredict && mp_q != '1) mp_d = mp_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PHT_ENTRIES; i++) pht_q[i] <= CNT_RST;
            ghr_q <= '0;
            br_q  <= '0;
            mp_q  <= '0;
        end else begin
            ghr_q <= ghr_d;
            br_q  <= br_d;
            mp_q  <= mp_d;
            if (bp.rdy && bp.upd_valid) pht_q[u_idx] <= u_cnt_d;
        end
    end

    assign unused_bits = ^{bp.q_pc[31:IDX_BITS+2], bp.q_pc[1:0],
                           bp.upd_pc[31:IDX_BITS+2], bp.upd_pc[1:0],
                           bp.upd_ghr[GHR_BITS-1]};
endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Bench for branch_predictor_gshare: a gshare and a bimodal instance share the same stimulus
// and are compared every cycle against an array-based model, plus directed scenario checks.
module tb_branch_predictor_gshare;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    branch_predictor_gshare_if #(.GHR_BITS(4), .STAT_BITS(4)) gi ();
    branch_predictor_gshare_if #(.GHR_BITS(4), .STAT_BITS(4)) bi ();

    assign bi.rdy            = gi.rdy;
    assign bi.q_valid        = gi.q_valid;
    assign bi.q_pc           = gi.q_pc;
    assign bi.q_inst         = gi.q_inst;
    assign bi.upd_valid      = gi.upd_valid;
    assign bi.upd_pc         = gi.upd_pc;
    assign bi.upd_ghr        = gi.upd_ghr;
    assign bi.upd_taken      = gi.upd_taken;
    assign bi.upd_mispredict = gi.upd_mispredict;

    branch_predictor_gshare #(
        .PHT_ENTRIES(16), .CNT_BITS(2), .CNT_INIT(1), .GHR_BITS(4), .USE_GSHARE(1), .STAT_BITS(4)
    ) dut_g (.clk(clk), .rst(rst), .bp(gi));

    branch_predictor_gshare #(
        .PHT_ENTRIES(16), .CNT_BITS(2), .CNT_INIT(1), .GHR_BITS(4), .USE_GSHARE(0), .STAT_BITS(4)
    ) dut_b (.clk(clk), .rst(rst), .bp(bi));

    always #5 clk = ~clk;

    // Model state: index 0 = gshare instance, 1 = bimodal instance.
    int m_pht [2][16];
    int m_ghr [2];
    int m_br;
    int m_mp;

    task automatic ck(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int m_idx(input int d, input logic [31:0] pc, input int ghr);
        int base;
        base = int'((pc >> 2) & 32'd15);
        return (d == 0) ? (base ^ ghr) : base;
    endfunction

    function automatic bit m_pred(input int d);
        if (!gi.q_valid) return 1'b0;
        if (gi.q_inst[6:0] == OP_JAL) return 1'b1;
        if (gi.q_inst[6:0] == OP_BR) return m_pht[d][m_idx(d, gi.q_pc, m_ghr[d])] >= 2;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_imm(input logic [31:0] i);
        int v;
        if (i[6:0] == OP_JAL)
            v = (i[31] ? -1048576 : 0) + int'(i[19:12]) * 4096 + int'(i[20]) * 2048
                + int'(i[30:21]) * 2;
        else
            v = (i[31] ? -4096 : 0) + int'(i[7]) * 2048 + int'(i[30:25]) * 32
                + int'(i[11:8]) * 2;
        return 32'(v);
    endfunction

    function automatic logic [31:0] make_b(input int imm);
        logic [12:0] m;
        m = 13'(imm);
        return {m[12], m[10:5], 5'd2, 5'd1, 3'b000, m[4:1], m[11], OP_BR};
    endfunction

    function automatic logic [31:0] make_j(input int imm);
        logic [20:0] m;
        m = 21'(imm);
        return {m[20], m[10:1], m[11], m[19:12], 5'd1, OP_JAL};
    endfunction

    task automatic m_reset();
        for (int d = 0; d < 2; d++) begin
            for (int e = 0; e < 16; e++) m_pht[d][e] = 1;
            m_ghr[d] = 0;
        end
        m_br = 0;
        m_mp = 0;
    endtask

    task automatic m_clock();
        bit p [2];
        int u;
        if (rst) begin
            m_reset();
        end else if (gi.rdy) begin
            for (int d = 0; d < 2; d++) p[d] = m_pred(d);
            for (int d = 0; d < 2; d++) begin
                if (gi.upd_valid) begin
                    u = m_idx(d, gi.upd_pc, int'(gi.upd_ghr));
                    if (gi.upd_taken) m_pht[d][u] = (m_pht[d][u] < 3) ? m_pht[d][u] + 1 : 3;
                    else              m_pht[d][u] = (m_pht[d][u] > 0) ? m_pht[d][u] - 1 : 0;
                end
                if (gi.upd_valid && gi.upd_mispredict)
                    m_ghr[d] = (int'(gi.upd_ghr) * 2 + int'(gi.upd_taken)) % 16;
                else if (gi.q_valid && gi.q_inst[6:0] == OP_BR)
                    m_ghr[d] = (m_ghr[d] * 2 + int'(p[d])) % 16;
            end
            if (gi.upd_valid) begin
                if (m_br < 15) m_br++;
                if (gi.upd_mispredict && m_mp < 15) m_mp++;
            end
        end
    endtask

    task automatic check_model();
        ck("g_pred_taken", 32'(gi.pred_taken), 32'(m_pred(0)));
        ck("g_pred_imm",   gi.pred_imm, m_imm(gi.q_inst));
        ck("g_pred_ghr",   32'(gi.pred_ghr), 32'(m_ghr[0]));
        ck("g_stat_br",    32'(gi.stat_branches), 32'(m_br));
        ck("g_stat_mp",    32'(gi.stat_mispredicts), 32'(m_mp));
        ck("b_pred_taken", 32'(bi.pred_taken), 32'(m_pred(1)));
        ck("b_pred_imm",   bi.pred_imm, m_imm(gi.q_inst));
        ck("b_pred_ghr",   32'(bi.pred_ghr), 32'(m_ghr[1]));
        ck("b_stat_br",    32'(bi.stat_branches), 32'(m_br));
        ck("b_stat_mp",    32'(bi.stat_mispredicts), 32'(m_mp));
    endtask

    task automatic settle();
        @(negedge clk);
        check_model();
    endtask

    task automatic tick();
        @(posedge clk);
        m_clock();
        #1;
    endtask

    task automatic cycle();
        settle();
        tick();
    endtask

    task automatic idle_inputs();
        gi.q_valid        = 1'b0;
        gi.upd_valid      = 1'b0;
        gi.upd_mispredict = 1'b0;
        gi.upd_taken      = 1'b0;
    endtask

    initial begin
        logic [31:0] r;
        int          exp_ghr [3];
        exp_ghr = '{0, 1, 3};

        m_reset();
        gi.rdy = 1'b1;
        gi.q_pc = 32'h0;
        gi.q_inst = 32'h0;
        gi.upd_pc = 32'h0;
        gi.upd_ghr = 4'h0;
        idle_inputs();
        rst = 1'b1;
        tick();
        cycle();
        rst = 1'b0;

        // Plain BEQ after reset: weakly not-taken, negative immediate.
        gi.q_valid = 1'b1;
        gi.q_pc    = 32'h100;
        gi.q_inst  = make_b(-8);
        settle();
        ck("t1_pred_taken", 32'(gi.pred_taken), 32'h0);
        ck("t1_pred_imm",   gi.pred_imm, 32'hFFFF_FFF8);
        ck("t1_pred_ghr",   32'(gi.pred_ghr), 32'h0);
        tick();
        gi.q_valid = 1'b0;
        settle();
        ck("t1_ghr_after", 32'(gi.pred_ghr), 32'h0);
        tick();

        // JAL is always taken and leaves the history alone.
        gi.q_valid = 1'b1;
        gi.q_inst  = make_j(2048);
        settle();
        ck("t2_pred_taken", 32'(gi.pred_taken), 32'h1);
        ck("t2_pred_imm",   gi.pred_imm, 32'h0000_0800);
        tick();
        gi.q_valid = 1'b0;
        settle();
        ck("t2_ghr_after", 32'(gi.pred_ghr), 32'h0);
        tick();

        // Bimodal training at 0x200: up to taken, then down without underflow.
        gi.upd_valid = 1'b1;
        gi.upd_pc    = 32'h200;
        gi.upd_taken = 1'b1;
        gi.upd_ghr   = 4'($urandom);
        cycle();
        cycle();
        gi.upd_valid = 1'b0;
        gi.q_valid   = 1'b1;
        gi.q_pc      = 32'h200;
        gi.q_inst    = make_b(16);
        settle();
        ck("t3_bimodal_taken", 32'(bi.pred_taken), 32'h1);
        tick();
        gi.q_valid   = 1'b0;
        gi.upd_valid = 1'b1;
        gi.upd_taken = 1'b0;
        for (int k = 0; k < 4; k++) cycle();
        gi.upd_taken = 1'b1;
        cycle();
        gi.upd_valid = 1'b0;
        gi.q_valid   = 1'b1;
        settle();
        ck("t3_bimodal_floor", 32'(bi.pred_taken), 32'h0);
        tick();

        // Speculative history shifts, then a recovery that overrides a 4th shift.
        idle_inputs();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        gi.upd_valid = 1'b1;
        gi.upd_pc    = 32'h100;
        gi.upd_taken = 1'b1;
        for (int k = 0; k < 3; k++) begin
            gi.upd_ghr = 4'(exp_ghr[k]);
            cycle();
            cycle();
        end
        gi.upd_valid = 1'b0;
        gi.q_valid   = 1'b1;
        gi.q_pc      = 32'h100;
        gi.q_inst    = make_b(-8);
        for (int k = 0; k < 3; k++) begin
            settle();
            ck("t4_spec_pred", 32'(gi.pred_taken), 32'h1);
            ck("t4_spec_ghr",  32'(gi.pred_ghr), 32'(exp_ghr[k]));
            tick();
        end
        gi.upd_valid      = 1'b1;
        gi.upd_mispredict = 1'b1;
        gi.upd_ghr        = 4'h1;
        gi.upd_taken      = 1'b0;
        gi.upd_pc         = 32'h300;
        settle();
        ck("t4_ghr_before_recover", 32'(gi.pred_ghr), 32'h7);
        tick();
        idle_inputs();
        settle();
        ck("t4_ghr_recovered", 32'(gi.pred_ghr), 32'h2);
        tick();

        // Read-before-write collision on the same PHT entry.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        gi.q_valid   = 1'b1;
        gi.q_pc      = 32'h100;
        gi.q_inst    = make_b(-8);
        gi.upd_valid = 1'b1;
        gi.upd_pc    = 32'h100;
        gi.upd_ghr   = 4'h0;
        gi.upd_taken = 1'b1;
        settle();
        ck("t5_collide_old", 32'(gi.pred_taken), 32'h0);
        tick();
        gi.upd_valid = 1'b0;
        settle();
        ck("t5_collide_new", 32'(gi.pred_taken), 32'h1);
        tick();

        // Statistics saturation, reset mid-stream, rdy hold.
        idle_inputs();
        gi.upd_valid      = 1'b1;
        gi.upd_mispredict = 1'b1;
        for (int k = 0; k < 17; k++) begin
            gi.upd_pc    = 32'($urandom_range(0, 63)) << 2;
            gi.upd_taken = 1'($urandom);
            gi.upd_ghr   = 4'($urandom);
            cycle();
        end
        settle();
        ck("t6_br_sat",   32'(gi.stat_branches), 32'hF);
        ck("t6_mp_sat",   32'(gi.stat_mispredicts), 32'hF);
        ck("t6_b_mp_sat", 32'(bi.stat_mispredicts), 32'hF);
        tick();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        gi.upd_valid = 1'b0;
        settle();
        ck("t6_rst_br",  32'(gi.stat_branches), 32'h0);
        ck("t6_rst_mp",  32'(gi.stat_mispredicts), 32'h0);
        ck("t6_rst_ghr", 32'(gi.pred_ghr), 32'h0);
        tick();
        gi.rdy            = 1'b0;
        gi.upd_valid      = 1'b1;
        gi.upd_mispredict = 1'b1;
        gi.upd_ghr        = 4'hF;
        gi.q_valid        = 1'b1;
        gi.q_inst         = make_j(64);
        for (int k = 0; k < 3; k++) cycle();
        settle();
        ck("t6_hold_br",  32'(gi.stat_branches), 32'h0);
        ck("t6_hold_ghr", 32'(gi.pred_ghr), 32'h0);
        ck("t6_hold_comb", 32'(gi.pred_taken), 32'h1);
        tick();
        gi.rdy = 1'b1;
        idle_inputs();

        // Random traffic against the model.
        for (int k = 0; k < 800; k++) begin
            rst               = ($urandom_range(0, 99) == 0);
            gi.rdy            = ($urandom_range(0, 7) != 0);
            gi.q_valid        = ($urandom_range(0, 3) != 0);
            gi.q_pc           = 32'($urandom_range(0, 63)) << 2;
            r                 = $urandom;
            case ($urandom_range(0, 3))
                0, 1: r[6:0] = OP_BR;
                2:    r[6:0] = OP_JAL;
                default: r[6:0] = ($urandom_range(0, 1) == 0) ? OP_JALR : r[6:0];
            endcase
            gi.q_inst         = r;
            gi.upd_valid      = ($urandom_range(0, 1) == 0);
            gi.upd_pc         = 32'($urandom_range(0, 63)) << 2;
            gi.upd_ghr        = 4'($urandom);
            gi.upd_taken      = 1'($urandom);
            gi.upd_mispredict = ($urandom_range(0, 3) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/branch_predictor_gshare.md
Name: branch_predictor_gshare

Overview:
- Parametrised successor to the bimodal 2-bit branch predictor in the Issue stage.
- Gives IF a same-cycle taken/not-taken prediction and the sign-extended J/B immediate for the fetched instruction.
- Keeps a speculative global history register (GHR) and a gshare- or bimodal-indexed pattern history table (PHT) of saturating counters, trained from ROB commit.
- Restores the GHR on misprediction and keeps branch and mispredict statistics counters.

Parameters:
PHT_ENTRIES, 256, PHT depth; power of two, 4..4096; IDX_BITS = log2(PHT_ENTRIES)
CNT_BITS, 2, counter width, 1..4
CNT_INIT, 1, counter value after reset (default: weakly not-taken)
GHR_BITS, 8, global history length, 1..IDX_BITS
USE_GSHARE, 1, 1: index = pc[IDX_BITS+1:2] XOR zero-extended GHR; 0: bimodal, index = pc[IDX_BITS+1:2]
STAT_BITS, 32, width of statistics counters

Ports:
clk  in  1  clock
rst  in  1  reset (see Behaviour)
rdy  in  1  global enable; when low, no state changes
q_valid  in  1  IF presents an instruction this cycle
q_pc  in  32  fetch PC
q_inst  in  32  fetched instruction
pred_taken  out  1  predicted taken (combinational)
pred_imm  out  32  J-immediate if JAL, else B-immediate (combinational)
pred_ghr  out  GHR_BITS  GHR snapshot used for this prediction; IF carries it to the ROB
upd_valid  in  1  ROB commits a conditional branch
upd_pc  in  32  PC of committed branch
upd_ghr  in  GHR_BITS  snapshot carried with that branch
upd_taken  in  1  resolved outcome
upd_mispredict  in  1  prediction was wrong; pipeline is flushed this cycle
stat_branches  out  STAT_BITS  committed conditional branches
stat_mispredicts  out  STAT_BITS  committed mispredictions

Behaviour:
- Reset: rst is synchronous and active-high, with clock clk.
  - On reset, all PHT entries become CNT_INIT, GHR = 0, and both stat counters = 0.
  - Reset takes priority over rdy and over all other inputs.
  - Combinational outputs reflect the reset state in the next cycle.
- Decode of q_inst:
  - Opcode 1101111 (JAL): pred_taken = 1.
  - Opcode 1100011 (BRANCH): pred_taken = MSB of PHT[q_idx].
  - Any other opcode, or q_valid = 0: pred_taken = 0.
  - JALR is never predicted taken.
  - pred_imm is a pure function of q_inst: J-immediate or B-immediate, sign-extended, bit 0 = 0.
- Indexing:
  - q_idx is computed from q_pc and the current GHR.
  - u_idx is computed from upd_pc and upd_ghr, using the same formula.
  - In bimodal mode the GHR is still maintained but does not affect the index.
- pred_ghr = current GHR register value, with zero latency.
- Speculative GHR update, on rdy && q_valid && BRANCH opcode, clocked: GHR <= {GHR[GHR_BITS-2:0], pred_taken}.
  - For GHR_BITS = 1: GHR <= pred_taken.
  - JAL and non-branches do not shift the GHR.
- Recovery, on rdy && upd_valid && upd_mispredict: GHR <= {upd_ghr[GHR_BITS-2:0], upd_taken}.
  - Recovery overrides a speculative shift in the same cycle (the query belongs to a flushed path).
- PHT training, on rdy && upd_valid:
  - Taken: PHT[u_idx] increments, saturating at 2^CNT_BITS-1.
  - Not taken: PHT[u_idx] decrements, saturating at 0.
  - Only one entry is written per cycle; 1-cycle write latency.
- Read/write collision: if q_idx == u_idx in the same cycle, the prediction uses the pre-update counter value (read-before-write). There is no bypass.
- Statistics:
  - stat_branches increments on rdy && upd_valid.
  - stat_mispredicts increments on rdy && upd_valid && upd_mispredict.
  - Both saturate at all-ones and never wrap.
- rdy = 0: PHT, GHR and stats hold. Combinational outputs still track the inputs.
- upd_mispredict is ignored when upd_valid = 0.

Test Plan:
1. Reset, then q_inst = BEQ (opcode 1100011) with imm = -8 at pc 0x100 -> pred_taken = 0, pred_imm = 0xFFFFFFF8, pred_ghr = 0; one clock later GHR = 0x00.
2. JAL with imm = +2048 -> pred_taken = 1, pred_imm = 0x00000800; GHR unchanged after the clock.
3. USE_GSHARE = 0, pc 0x200, upd taken twice -> counter goes 1→2→3 and the next BEQ query at 0x200 gives pred_taken = 1; four not-taken updates -> counter 0, no underflow.
4. Speculative shifts: three taken-predicted branches move GHR 0x00→0x01→0x03→0x07. Same cycle as a 4th query: upd_mispredict = 1, upd_ghr = 0x01, upd_taken = 0 -> GHR = 0x02 and the 4th shift is discarded.
5. Collision: query and update hit the same index with counter = 1, update taken -> pred_taken = 0 that cycle; next cycle pred_taken = 1.
6. STAT_BITS = 4: 17 mispredicting updates -> both stats stick at 0xF. Assert rst mid-stream -> stats = 0, GHR = 0, all counters = CNT_INIT. rdy = 0 with upd_valid = 1 -> no change.
